mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
Initiator-side controller that drives the mac accumulator block to compute one signed dot product per job. It accepts a job (vector length plus ReLU select), streams operand pairs from an upstream valid/ready source into the mac operand/enable/clear interface, and waits out the mac pipeline. It then captures the accumulator, requantizes it to int8 (round, shift, saturate, optional ReLU) and presents the result on a valid/ready output. It sits between the activation/weight fetch logic and the mac instance in each neuron lane.

Parameters:
DATA_W, 8, operand width and requantized result width (signed)
ACC_W, 24, mac accumulator width (signed)
LEN_W, 8, width of vector-length field; max length 2^LEN_W-1
MAC_LATENCY, 1, cycles from mac_en sample edge until mac_out reflects that product
OUT_SHIFT, 0, arithmetic right shift applied in requantization

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  job request; accepted only when busy=0
len  in  LEN_W  number of operand pairs; latched on start acceptance
relu_en  in  1  ReLU select; latched on start acceptance
busy  out  1  high from the cycle after start acceptance until the result handshake completes
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer can take a pair
in_a  in  DATA_W  signed operand a
in_b  in  DATA_W  signed operand b
mac_clr  out  1  to mac reset (active-high), clears accumulator
mac_en  out  1  to mac enable
mac_a  out  DATA_W  to mac a
mac_b  out  DATA_W  to mac b
mac_out  in  ACC_W  from mac out
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  DATA_W  requantized signed result
res_acc  out  ACC_W  raw captured accumulator

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; busy, in_ready, mac_en, res_valid=0; mac_clr=1 for that cycle, then 0; mac_a, mac_b, res_data, res_acc=0; counters=0. Reset mid-job abandons the job; no result is emitted.
- All outputs are registered except in_ready, which is decoded from state (in_ready=1 iff state=STREAM and remaining count>0).
- IDLE: start=1 -> latch len and relu_en; go to CLEAR. start is ignored while busy=1.
- CLEAR: exactly one cycle with mac_clr=1 and mac_en=0. Next state is STREAM if len>0, otherwise DRAIN.
- STREAM: a transfer occurs when in_valid&&in_ready. On a transfer edge: mac_a<=in_a, mac_b<=in_b, mac_en<=1, remaining decrements. A cycle with no transfer drives mac_en<=0 and holds mac_a/mac_b. Gaps in in_valid are legal and do not affect the result. After the edge of the last transfer, go to DRAIN.
- DRAIN: mac_en=1 for the first cycle only (last pair), then 0. State lasts MAC_LATENCY+1 cycles. At its final edge, res_acc<=mac_out, res_data<=requant(mac_out), res_valid<=1; go to OUTPUT. When len=0, mac_out is the cleared value 0.
- requant(x): if OUT_SHIFT>0, add 2^(OUT_SHIFT-1) (round half up), then arithmetic shift right by OUT_SHIFT. The sum is computed at ACC_W+1 bits with no overflow. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. If relu_en and the result is <0, output 0.
- OUTPUT: res_valid, res_data and res_acc are held stable until res_ready=1. On that edge, res_valid<=0, busy<=0 and state returns to IDLE. start is accepted again on the following cycle. There is no same-cycle start/result overlap.
- Width: worst case (2^LEN_W-1)*(-128*-128)=4,177,920 fits ACC_W=24 signed. The mac is never driven beyond len pairs, so no overflow checks are required.

Test Plan:
- len=2, relu_en=0, OUT_SHIFT=0, pairs (15,10),(25,20) back-to-back -> exactly one mac_clr pulse, then mac_en high 2 cycles; res_acc=650, res_data=127 (saturated).
- Same job with OUT_SHIFT=4 -> res_acc=650, res_data=41 ((650+8)>>4).
- len=2, pairs (-100,-50),(-128,127), in_valid low for 3 cycles between pairs -> mac_en high only on transfer cycles; res_acc=-11256, res_data=-128. Repeat with relu_en=1 -> res_data=0.
- len=0 -> no in_ready, no mac_en; res_acc=0, res_data=0, busy drops after res_ready.
- res_ready held low 5 cycles; start pulsed during busy -> res_valid and data stable, start ignored; next start accepted one cycle after the handshake, with the accumulator cleared (second job len=1 (3,4) -> res_acc=12).
- reset=0 asserted mid-STREAM after 1 of 3 pairs -> IDLE, res_valid never asserted, mac_clr pulses; new job len=1 (-1,1) -> res_acc=-1.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Job sequencer for the mac accumulator: streams len operand pairs into the mac,
// waits out its pipeline, then requantizes the accumulator to int8 on a valid/ready port.
module mac_dot_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 24,
  parameter int LEN_W       = 8,
  parameter int MAC_LATENCY = 1,
  parameter int OUT_SHIFT   = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              relu_en_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_a_i,
  input  logic [DATA_W-1:0] in_b_i,
  output logic              mac_clr_o,
  output logic              mac_en_o,
  output logic [DATA_W-1:0] mac_a_o,
  output logic [DATA_W-1:0] mac_b_o,
  input  logic [ACC_W-1:0]  mac_out_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic [ACC_W-1:0]  res_acc_o
);

  localparam int CNT_W = $clog2(MAC_LATENCY + 2);
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2**OUT_SHIFT / 2);
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, OUTPUT} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              relu_q, relu_d;
  logic              busy_q, busy_d;
  logic              mac_clr_q, mac_clr_d;
  logic              mac_en_q, mac_en_d;
  logic [DATA_W-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ACC_W-1:0]  res_acc_q, res_acc_d;

  logic signed [ACC_W:0]  rq_sum, rq_sh;
  logic [DATA_W-1:0]      rq_val;
  logic                   xfer;

  assign in_ready_o = (state_q == STREAM) && (rem_q != '0);
  assign xfer       = in_valid_i && in_ready_o;

  // Round half up at ACC_W+1 bits so the rounding add can never wrap.
  always_comb begin
    rq_sum = $signed({mac_out_i[ACC_W-1], mac_out_i}) + RND;
    rq_sh  = rq_sum >>> OUT_SHIFT;
    if (rq_sh > MAXV)      rq_val = MAXV[DATA_W-1:0];
    else if (rq_sh < MINV) rq_val = MINV[DATA_W-1:0];
    else                   rq_val = rq_sh[DATA_W-1:0];
    if (relu_q && rq_val[DATA_W-1]) rq_val = '0;
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dcnt_d      = dcnt_q;
    relu_d      = relu_q;
    busy_d      = busy_q;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_acc_d   = res_acc_q;
    case (state_q)
      IDLE: if (start_i) begin
        rem_d     = len_i;
        relu_d    = relu_en_i;
        busy_d    = 1'b1;
        mac_clr_d = 1'b1;
        state_d   = CLEAR;
      end
      CLEAR: begin
        dcnt_d  = '0;
        state_d = (rem_q != '0) ? STREAM : DRAIN;
      end
      STREAM: if (xfer) begin
        mac_a_d  = in_a_i;
        mac_b_d  = in_b_i;
        mac_en_d = 1'b1;
        rem_d    = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last product lands in mac_out MAC_LATENCY cycles after its enable.
        if (dcnt_q == CNT_W'(MAC_LATENCY)) begin
          res_acc_d   = mac_out_i;
          res_data_d  = rq_val;
          res_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      OUTPUT: if (res_ready_i) begin
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dcnt_q      <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      mac_clr_q   <= 1'b1;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dcnt_q      <= dcnt_d;
      relu_q      <= relu_d;
      busy_q      <= busy_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_acc_q   <= res_acc_d;
    end
  end

  assign busy_o      = busy_q;
  assign mac_clr_o   = mac_clr_q;
  assign mac_en_o    = mac_en_q;
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_acc_o   = res_acc_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: two instances (OUT_SHIFT 0 and 4) share stimulus and a
// behavioural mac; results are checked against table constants and a dot-product model.
module tb_mac_dot_sequencer;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rst_n, start, relu_en, in_valid, res_ready;
  logic [7:0]  len, in_a, in_b;
  logic        busy, in_ready, mac_clr, mac_en, res_valid;
  logic [7:0]  mac_a, mac_b, res_data;
  logic [23:0] res_acc;
  logic        busy4, in_ready4, mac_clr4, mac_en4, res_valid4;
  logic [7:0]  mac_a4, mac_b4, res_data4;
  logic [23:0] res_acc4;
  logic signed [23:0] acc_m;

  mac_dot_sequencer #(.OUT_SHIFT(0)) u0 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start), .len_i(len), .relu_en_i(relu_en),
    .busy_o(busy), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_a_i(in_a), .in_b_i(in_b),
    .mac_clr_o(mac_clr), .mac_en_o(mac_en), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_out_i(acc_m),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data), .res_acc_o(res_acc));

  mac_dot_sequencer #(.OUT_SHIFT(4)) u4 (
    .clk_i(clk), .reset_i(rst_n), .start_i(start), .len_i(len), .relu_en_i(relu_en),
    .busy_o(busy4), .in_valid_i(in_valid), .in_ready_o(in_ready4), .in_a_i(in_a), .in_b_i(in_b),
    .mac_clr_o(mac_clr4), .mac_en_o(mac_en4), .mac_a_o(mac_a4), .mac_b_o(mac_b4), .mac_out_i(acc_m),
    .res_valid_o(res_valid4), .res_ready_i(res_ready), .res_data_o(res_data4), .res_acc_o(res_acc4));

  // Behavioural mac with one cycle of latency, driven by the shift-0 instance.
  always @(posedge clk) begin
    if (mac_clr)     acc_m <= '0;
    else if (mac_en) acc_m <= acc_m + $signed(mac_a) * $signed(mac_b);
  end

  int clr_cnt = 0, en_cnt = 0, rdy_cnt = 0;
  always @(negedge clk) begin
    if (mac_clr)  clr_cnt++;
    if (mac_en)   en_cnt++;
    if (in_ready) rdy_cnt++;
  end

  int n_chk = 0, n_fail = 0;
  int ja[16], jb[16];

  typedef struct {
    int n; bit relu; int a[4]; int b[4]; int gap; int rdly; int eacc; int ed0; int ed4;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_rq(input int acc, input int sh, input bit relu);
    int v;
    v = (sh > 0) ? ((acc + (1 << (sh - 1))) >>> sh) : acc;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    if (relu && v < 0) v = 0;
    return v;
  endfunction

  task automatic xfer(input int a, input int b, output bit taken);
    int w;
    in_valid = 1; in_a = a[7:0]; in_b = b[7:0];
    taken = 0; w = 0;
    while (!taken && w < 20) begin
      taken = in_ready;
      @(posedge clk); #1;
      w++;
    end
    in_valid = 0;
  endtask

  task automatic do_job(input int n, input bit relu, input int gap, input int rdly,
                        output int acc, output int d0, output int d4);
    int clr0, en0, rdy0, w;
    bit t;
    len = n[7:0]; relu_en = relu; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", int'(busy), 1);
    clr0 = clr_cnt; en0 = en_cnt; rdy0 = rdy_cnt;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      xfer(ja[i], jb[i], t);
      chk("pair_taken", int'(t), 1);
    end
    w = 0;
    while (!res_valid && w < 20) begin @(posedge clk); #1; w++; end
    chk("res_valid_seen", int'(res_valid), 1);
    chk("clr_pulses", clr_cnt - clr0, 1);
    chk("en_cycles", en_cnt - en0, n);
    chk("ready_cycles", rdy_cnt - rdy0, (n > 0) ? n + gap * (n - 1) : 0);
    acc = int'($signed(res_acc));
    d0  = int'($signed(res_data));
    d4  = int'($signed(res_data4));
    // A start pulse while the result waits must be ignored.
    start = (rdly >= 2); len = 8'd1;
    for (int k = 0; k < rdly; k++) begin
      @(posedge clk); #1;
      start = 0;
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_busy", int'(busy), 1);
      chk("hold_acc", int'($signed(res_acc)), acc);
      chk("hold_data", int'($signed(res_data)), d0);
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("valid_drop", int'(res_valid), 0);
    chk("busy_drop", int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int acc, d0, d4;
    for (int i = 0; i < 4; i++) begin ja[i] = v.a[i]; jb[i] = v.b[i]; end
    do_job(v.n, v.relu, v.gap, v.rdly, acc, d0, d4);
    chk({nm, "_acc"}, acc, v.eacc);
    chk({nm, "_d0"}, d0, v.ed0);
    chk({nm, "_d4"}, d4, v.ed4);
  endtask

  initial begin
    int acc, d0, d4, exp_acc, n, gap, rdly, rv;
    bit relu, t;
    vt[0] = '{2, 0, '{15, 25, 0, 0},    '{10, 20, 0, 0},   0, 0, 650,    127,  41};
    vt[1] = '{2, 0, '{-100, -128, 0, 0}, '{-50, 127, 0, 0}, 3, 1, -11256, -128, -128};
    vt[2] = '{2, 1, '{-100, -128, 0, 0}, '{-50, 127, 0, 0}, 3, 0, -11256, 0,    0};
    vt[3] = '{0, 0, '{0, 0, 0, 0},      '{0, 0, 0, 0},     1, 2, 0,      0,    0};
    vt[4] = '{1, 0, '{-4, 0, 0, 0},     '{6, 0, 0, 0},     0, 0, -24,    -24,  -1};
    vt[5] = '{1, 0, '{2, 0, 0, 0},      '{4, 0, 0, 0},     0, 0, 8,      8,    1};
    vt[6] = '{1, 1, '{7, 0, 0, 0},      '{1, 0, 0, 0},     2, 0, 7,      7,    0};
    vt[7] = '{3, 1, '{2, -1, 5, 0},     '{3, 4, -1, 0},    1, 1, -3,     0,    0};
    vt[8] = '{2, 0, '{127, 127, 0, 0},  '{127, 127, 0, 0}, 0, 0, 32258,  127,  127};

    rst_n = 0; start = 0; len = 0; relu_en = 0; in_valid = 0; in_a = 0; in_b = 0; res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_mac_clr", int'(mac_clr), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_acc", int'(res_acc), 0);
    chk("rst_mac_ab", int'({mac_a, mac_b}), 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rst_clr_drop", int'(mac_clr), 0);

    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Result stalled 5 cycles with a start pulse, then an immediate follow-up job.
    ja[0] = 15; jb[0] = 10; ja[1] = 25; jb[1] = 20;
    do_job(2, 0, 0, 5, acc, d0, d4);
    chk("stall_acc", acc, 650);
    chk("stall_d4", d4, 41);
    ja[0] = 3; jb[0] = 4;
    do_job(1, 0, 0, 0, acc, d0, d4);
    chk("after_stall_acc", acc, 12);
    chk("after_stall_d4", d4, 1);

    // Reset after the first of three pairs abandons the job.
    len = 8'd3; relu_en = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    xfer(5, 3, t);
    chk("rst_mid_pair", int'(t), 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_mac_clr", int'(mac_clr), 1);
    chk("mid_rst_mac_en", int'(mac_en), 0);
    rst_n = 1;
    rv = 0;
    repeat (10) begin @(posedge clk); #1; if (res_valid) rv++; end
    chk("mid_rst_no_result", rv, 0);
    ja[0] = -1; jb[0] = 1;
    do_job(1, 0, 0, 0, acc, d0, d4);
    chk("post_rst_acc", acc, -1);
    chk("post_rst_d0", d0, -1);
    chk("post_rst_d4", d4, 0);

    // Random jobs against the dot-product model.
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 6); gap = $urandom_range(0, 2);
      rdly = $urandom_range(0, 3); relu = 1'($urandom_range(0, 1));
      exp_acc = 0;
      for (int i = 0; i < n; i++) begin
        ja[i] = int'($urandom_range(0, 255)) - 128;
        jb[i] = int'($urandom_range(0, 255)) - 128;
        exp_acc += ja[i] * jb[i];
      end
      do_job(n, relu, gap, rdly, acc, d0, d4);
      chk("rand_acc", acc, exp_acc);
      chk("rand_d0", d0, model_rq(exp_acc, 0, relu));
      chk("rand_d4", d4, model_rq(exp_acc, 4, relu));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
